// File: rtl/corner_editor_pkg.sv
// Shared definitions for the corner editor: acceleration FSM encoding,
// selection width helper and the default-rectangle corner table.
package corner_editor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLOW = 2'd1,
        ST_FAST = 2'd2
    } accel_state_t;

    localparam logic [1:0] DIR_NEG  = 2'b11;
    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_POS  = 2'b01;

    function automatic int sel_width(input int num);
        return (num <= 2) ? 1 : $clog2(num);
    endfunction

    // Corners beyond the fourth repeat the rectangle pattern clockwise from top-left.
    function automatic int default_x(input int idx, input int x_max, input int inset);
        case (idx % 4)
            1, 2:    return x_max - inset;
            default: return inset;
        endcase
    endfunction

    function automatic int default_y(input int idx, input int y_max, input int inset);
        case (idx % 4)
            2, 3:    return y_max - inset;
            default: return inset;
        endcase
    endfunction

endpackage

// File: rtl/corner_editor_coord_stepper.sv
// One-axis coordinate stepper: moves a value by +/-step and clamps to [0, max].
// Purely combinational; the caller registers the result.
module corner_editor_coord_stepper
    import corner_editor_pkg::*;
#(
    parameter int COORD_W = 10
) (
    input  logic [COORD_W-1:0] i_value,
    input  logic [1:0]         i_dir,
    input  logic [COORD_W-1:0] i_step,
    input  logic [COORD_W-1:0] i_max,
    output logic [COORD_W-1:0] o_next
);

    // Two guard bits keep value+step from overflowing into the sign.
    logic signed [COORD_W+1:0] w_val;
    logic signed [COORD_W+1:0] w_step;
    logic signed [COORD_W+1:0] w_max;
    logic signed [COORD_W+1:0] w_sum;

    assign w_val  = $signed({2'b00, i_value});
    assign w_step = $signed({2'b00, i_step});
    assign w_max  = $signed({2'b00, i_max});

    always_comb begin
        w_sum = w_val;
        if (i_dir == DIR_POS) begin
            w_sum = w_val + w_step;
        end else if (i_dir == DIR_NEG) begin
            w_sum = w_val - w_step;
        end
    end

    always_comb begin
        o_next = w_sum[COORD_W-1:0];
        if (w_sum < 0) begin
            o_next = '0;
        end else if (w_sum > w_max) begin
            o_next = i_max;
        end
    end

endmodule

// File: rtl/corner_editor.sv
// Push-button editor for NUM_CORNERS corner points; all state changes once per field rising edge.
// Outputs are registered and update on the clock edge that samples the frame tick.
module corner_editor
    import corner_editor_pkg::*;
#(
    parameter int NUM_CORNERS = 4,
    parameter int COORD_W     = 10,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int INSET       = 32,
    parameter int STEP_SLOW   = 1,
    parameter int STEP_FAST   = 8,
    parameter int HOLD_FRAMES = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             field,
    input  logic                             left_button,
    input  logic                             right_button,
    input  logic                             up_button,
    input  logic                             down_button,
    input  logic [NUM_CORNERS-1:0]           sel_buttons,
    input  logic                             restore_button,
    output logic [NUM_CORNERS*COORD_W-1:0]   corners_x,
    output logic [NUM_CORNERS*COORD_W-1:0]   corners_y,
    output logic [sel_width(NUM_CORNERS)-1:0] selected,
    output logic                             fast_mode
);

    localparam int SEL_W = sel_width(NUM_CORNERS);
    localparam int CNT_W = $clog2(HOLD_FRAMES) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);

    logic                 r_field_q;
    logic [SEL_W-1:0]     r_sel;
    accel_state_t         r_state;
    logic [CNT_W-1:0]     r_hold_cnt;
    logic [3:0]           r_dirs_q;
    logic [COORD_W-1:0]   r_x [NUM_CORNERS];
    logic [COORD_W-1:0]   r_y [NUM_CORNERS];

    logic                 w_tick;
    logic [3:0]           w_dirs;
    logic                 w_sel_vld;
    logic [SEL_W-1:0]     w_sel_req;
    logic                 w_sel_change;
    accel_state_t         w_state_next;
    logic [CNT_W-1:0]     w_hold_next;
    logic                 w_fast_next;
    logic [1:0]           w_dx;
    logic [1:0]           w_dy;
    logic [COORD_W-1:0]   w_step;
    logic [COORD_W-1:0]   w_x_next;
    logic [COORD_W-1:0]   w_y_next;
    logic [COORD_W-1:0]   w_def_x [NUM_CORNERS];
    logic [COORD_W-1:0]   w_def_y [NUM_CORNERS];

    assign w_tick = field & ~r_field_q;
    assign w_dirs = {left_button, right_button, up_button, down_button};

    always_comb begin
        w_sel_req = '0;
        for (int i = NUM_CORNERS - 1; i >= 0; i--) begin
            if (sel_buttons[i]) begin
                w_sel_req = SEL_W'(i);
            end
        end
    end

    assign w_sel_vld    = |sel_buttons;
    assign w_sel_change = w_sel_vld && (w_sel_req != r_sel);

    // Acceleration FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_dirs_q   <= '0;
        end else if (w_tick) begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_next;
            r_dirs_q   <= w_dirs;
        end
    end

    // Acceleration FSM: next state (only consumed on a tick)
    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold_cnt;
        if (w_sel_change || (w_dirs == 4'b0000)) begin
            w_state_next = ST_IDLE;
            w_hold_next  = '0;
        end else if (w_dirs != r_dirs_q) begin
            w_state_next = ST_SLOW;
            w_hold_next  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_SLOW;
                    w_hold_next  = '0;
                end
                ST_SLOW: begin
                    if ((r_hold_cnt + CNT_W'(1)) >= HOLD_LAST) begin
                        w_state_next = ST_FAST;
                        w_hold_next  = HOLD_LAST;
                    end else begin
                        w_hold_next = r_hold_cnt + CNT_W'(1);
                    end
                end
                ST_FAST: w_state_next = ST_FAST;
                default: begin
                    w_state_next = ST_IDLE;
                    w_hold_next  = '0;
                end
            endcase
        end
    end

    // Acceleration FSM: outputs
    always_comb begin
        fast_mode   = (r_state == ST_FAST);
        w_fast_next = (w_state_next == ST_FAST);
    end

    // The tick that enters FAST already moves by the fast step.
    assign w_step = w_fast_next ? COORD_W'(STEP_FAST) : COORD_W'(STEP_SLOW);

    always_comb begin
        w_dx = DIR_NONE;
        if (right_button && !left_button) w_dx = DIR_POS;
        if (left_button && !right_button) w_dx = DIR_NEG;
        w_dy = DIR_NONE;
        if (down_button && !up_button)    w_dy = DIR_POS;
        if (up_button && !down_button)    w_dy = DIR_NEG;
    end

    corner_editor_coord_stepper #(.COORD_W(COORD_W)) u_step_x (
        .i_value (r_x[r_sel]),
        .i_dir   (w_dx),
        .i_step  (w_step),
        .i_max   (COORD_W'(X_MAX)),
        .o_next  (w_x_next)
    );

    corner_editor_coord_stepper #(.COORD_W(COORD_W)) u_step_y (
        .i_value (r_y[r_sel]),
        .i_dir   (w_dy),
        .i_step  (w_step),
        .i_max   (COORD_W'(Y_MAX)),
        .o_next  (w_y_next)
    );

    for (genvar g = 0; g < NUM_CORNERS; g++) begin : g_corner
        assign w_def_x[g] = COORD_W'(default_x(g, X_MAX, INSET));
        assign w_def_y[g] = COORD_W'(default_y(g, Y_MAX, INSET));
        assign corners_x[g*COORD_W +: COORD_W] = r_x[g];
        assign corners_y[g*COORD_W +: COORD_W] = r_y[g];
    end

    // Edits land on the selection in force before this tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_field_q <= 1'b0;
            r_sel     <= '0;
            for (int i = 0; i < NUM_CORNERS; i++) begin
                r_x[i] <= w_def_x[i];
                r_y[i] <= w_def_y[i];
            end
        end else begin
            r_field_q <= field;
            if (w_tick) begin
                if (restore_button) begin
                    r_x[r_sel] <= w_def_x[r_sel];
                    r_y[r_sel] <= w_def_y[r_sel];
                end else begin
                    r_x[r_sel] <= w_x_next;
                    r_y[r_sel] <= w_y_next;
                end
                if (w_sel_vld) begin
                    r_sel <= w_sel_req;
                end
            end
        end
    end

    assign selected = r_sel;

endmodule

// File: tb/tb_corner_editor.sv
// Bench for corner_editor: table of button vectors with expected corner state,
// plus hand-written reset and held-field sequences.
module tb_corner_editor;

    localparam int NC = 4;
    localparam int CW = 10;
    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] L    = 4'b1000;
    localparam logic [3:0] R    = 4'b0100;
    localparam logic [3:0] U    = 4'b0010;
    localparam logic [3:0] D    = 4'b0001;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              field = 1'b0;
    logic              left_button = 1'b0;
    logic              right_button = 1'b0;
    logic              up_button = 1'b0;
    logic              down_button = 1'b0;
    logic [NC-1:0]     sel_buttons = '0;
    logic              restore_button = 1'b0;
    logic [NC*CW-1:0]  corners_x;
    logic [NC*CW-1:0]  corners_y;
    logic [1:0]        selected;
    logic              fast_mode;

    corner_editor dut (
        .clk            (clk),
        .reset          (reset),
        .field          (field),
        .left_button    (left_button),
        .right_button   (right_button),
        .up_button      (up_button),
        .down_button    (down_button),
        .sel_buttons    (sel_buttons),
        .restore_button (restore_button),
        .corners_x      (corners_x),
        .corners_y      (corners_y),
        .selected       (selected),
        .fast_mode      (fast_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dirs;
        logic [3:0] sel;
        logic       rst_btn;
        int         reps;
        int         ci;
        int         ex;
        int         ey;
        int         es;
        logic       ef;
    } vec_t;

    typedef struct {
        int   tag;
        int   ci;
        int   ex;
        int   ey;
        int   es;
        logic ef;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic [3:0] d, input logic [3:0] s, input logic rb,
                                input int reps, input int ci, input int ex, input int ey,
                                input int es, input logic ef);
        vec_t v;
        v.dirs = d; v.sel = s; v.rst_btn = rb; v.reps = reps;
        v.ci = ci; v.ex = ex; v.ey = ey; v.es = es; v.ef = ef;
        return v;
    endfunction

    task automatic drive(input logic [3:0] d, input logic [3:0] s, input logic rb);
        {left_button, right_button, up_button, down_button} = d;
        sel_buttons    = s;
        restore_button = rb;
    endtask

    task automatic tick();
        @(negedge clk); field = 1'b1;
        @(negedge clk);
        @(negedge clk); field = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_exp(input int tag, input int ci, input int ex, input int ey,
                            input int es, input logic ef);
        exp_t e;
        e.tag = tag; e.ci = ci; e.ex = ex; e.ey = ey; e.es = es; e.ef = ef;
        exp_q.push_back(e);
    endtask

    task automatic check_next();
        exp_t e;
        int   ax, ay;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e  = exp_q.pop_front();
        ax = int'(corners_x[e.ci*CW +: CW]);
        ay = int'(corners_y[e.ci*CW +: CW]);
        n_vec++;
        if (ax != e.ex || ay != e.ey || int'(selected) != e.es || fast_mode !== e.ef) begin
            n_bad++;
            $display("FAIL vec%0d corner%0d: got x=%0d y=%0d sel=%0d fast=%0b, want x=%0d y=%0d sel=%0d fast=%0b",
                     e.tag, e.ci, ax, ay, selected, fast_mode, e.ex, e.ey, e.es, e.ef);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Defaults with INSET=32 on a 640x480 screen
        vecs.push_back(mk(NONE, 4'b0000, 0, 1, 0,  32,  32, 0, 0));
        vecs.push_back(mk(NONE, 4'b0000, 0, 0, 2, 607, 447, 0, 0));
        // Hold right: 15 slow ticks, tick 16 switches to fast and uses the fast step
        vecs.push_back(mk(R,    4'b0000, 0, 15, 0,  47, 32, 0, 0));
        vecs.push_back(mk(R,    4'b0000, 0, 1,  0,  55, 32, 0, 1));
        vecs.push_back(mk(R,    4'b0000, 0, 4,  0,  87, 32, 0, 1));
        vecs.push_back(mk(NONE, 4'b0000, 0, 1,  0,  87, 32, 0, 0));
        // Left clamp at zero while fast
        vecs.push_back(mk(NONE, 4'b0000, 1, 1,  0,  32, 32, 0, 0));
        vecs.push_back(mk(L,    4'b0000, 0, 6,  0,  26, 32, 0, 0));
        vecs.push_back(mk(NONE, 4'b0000, 0, 1,  0,  26, 32, 0, 0));
        vecs.push_back(mk(L,    4'b0000, 0, 15, 0,  11, 32, 0, 0));
        vecs.push_back(mk(L,    4'b0000, 0, 1,  0,   3, 32, 0, 1));
        vecs.push_back(mk(L,    4'b0000, 0, 1,  0,   0, 32, 0, 1));
        vecs.push_back(mk(L,    4'b0000, 0, 3,  0,   0, 32, 0, 1));
        vecs.push_back(mk(NONE, 4'b0000, 0, 1,  0,   0, 32, 0, 0));
        // Down clamp at Y_MAX on corner 2, kept slow by releasing between holds
        vecs.push_back(mk(NONE, 4'b0100, 0, 1,  2, 607, 447, 2, 0));
        vecs.push_back(mk(D,    4'b0000, 0, 15, 2, 607, 462, 2, 0));
        vecs.push_back(mk(NONE, 4'b0000, 0, 1,  2, 607, 462, 2, 0));
        vecs.push_back(mk(D,    4'b0000, 0, 14, 2, 607, 476, 2, 0));
        vecs.push_back(mk(NONE, 4'b0000, 0, 1,  2, 607, 476, 2, 0));
        vecs.push_back(mk(D,    4'b0000, 0, 5,  2, 607, 479, 2, 0));
        vecs.push_back(mk(NONE, 4'b0000, 0, 1,  0,   0,  32, 2, 0));
        // Opposing x buttons cancel; selection takes effect after the move
        vecs.push_back(mk(NONE,  4'b0010, 0, 1, 1, 607, 32, 1, 0));
        vecs.push_back(mk(L|R|D, 4'b0110, 0, 1, 1, 607, 33, 1, 0));
        vecs.push_back(mk(D,     4'b0100, 0, 1, 1, 607, 34, 2, 0));
        vecs.push_back(mk(NONE,  4'b0000, 0, 0, 2, 607, 479, 2, 0));
        // Diagonal move on corner 3, then restore overriding a move
        vecs.push_back(mk(NONE, 4'b1000, 0, 1, 3,  32, 447, 3, 0));
        vecs.push_back(mk(R|U,  4'b0000, 0, 3, 3,  35, 444, 3, 0));
        vecs.push_back(mk(U,    4'b0000, 1, 1, 3,  32, 447, 3, 0));
        vecs.push_back(mk(NONE, 4'b0000, 0, 0, 1, 607,  34, 3, 0));
        vecs.push_back(mk(NONE, 4'b0000, 0, 0, 0,   0,  32, 3, 0));
        vecs.push_back(mk(NONE, 4'b0000, 0, 0, 2, 607, 479, 3, 0));
        // Selection change while fast drops back to idle and the slow step
        vecs.push_back(mk(R,    4'b0000, 0, 16, 3, 55, 447, 3, 1));
        vecs.push_back(mk(R,    4'b0001, 0, 1,  3, 56, 447, 0, 0));
        vecs.push_back(mk(NONE, 4'b0000, 0, 1,  3, 56, 447, 0, 0));

        repeat (3) @(negedge clk);
        reset = 1'b0;
        push_exp(-1, 0, 32, 32, 0, 0);
        check_next();
        push_exp(-2, 2, 607, 447, 0, 0);
        check_next();

        foreach (vecs[k]) begin
            drive(vecs[k].dirs, vecs[k].sel, vecs[k].rst_btn);
            push_exp(k, vecs[k].ci, vecs[k].ex, vecs[k].ey, vecs[k].es, vecs[k].ef);
            for (int r = 0; r < vecs[k].reps; r++) tick();
            check_next();
        end

        // Reach fast mode on corner 0, then reset between ticks
        drive(R, 4'b0000, 1'b0);
        push_exp(100, 0, 23, 32, 0, 1);
        for (int r = 0; r < 16; r++) tick();
        check_next();

        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        push_exp(101, 0, 32, 32, 0, 0);
        check_next();
        push_exp(102, 3, 32, 447, 0, 0);
        check_next();

        // One rising edge held high for many cycles moves exactly once
        field = 1'b1;
        repeat (10) @(negedge clk);
        push_exp(103, 0, 33, 32, 0, 0);
        check_next();
        field = 1'b0;
        repeat (3) @(negedge clk);
        push_exp(104, 0, 33, 32, 0, 0);
        check_next();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
